// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID queue.
// The fetch side pushes {instruction, NPC} pairs with in_valid/in_ready.
// The decode side pops them with out_valid/out_ready.
// flush redirects the PC and discards queued entries.
interface if_id_queue_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_instruction;
  logic [DATA_W-1:0] in_npc;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_instruction;
  logic [DATA_W-1:0] out_npc;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  // Pipeline side: drives fetch data, flush and the decode stall.
  modport master (
    output in_valid, in_instruction, in_npc, flush, out_ready,
    input  in_ready, out_valid, out_instruction, out_npc, count
  );

  // Queue side.
  modport slave (
    input  in_valid, in_instruction, in_npc, flush, out_ready,
    output in_ready, out_valid, out_instruction, out_npc, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID queue: a small FIFO that decouples the fetch stage from decode.
// A decode stall therefore does not drop fetched instructions. On a PC
// redirect, flush drops every wrong-path entry together with any push
// in the same cycle. The outputs are read combinationally from the head
// entry. A push is visible one cycle later, because there is no bypass.
module if_id_queue #(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
  input logic          clk,
  input logic          reset,
  if_id_queue_if.slave bus
);
  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  // Each entry packs the instruction in the upper half and the NPC in the lower half.
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_q;

  logic                in_ready;
  logic                out_valid;
  logic                push;
  logic                pop;
  logic [2*DATA_W-1:0] head;

  // Handshake qualifiers. A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    in_ready  = (count_q < DEPTH_C) | bus.out_ready;
    out_valid = (count_q != '0);
    push      = bus.in_valid & in_ready  & ~bus.flush;
    pop       = out_valid    & bus.out_ready & ~bus.flush;
  end

  // Storage writes happen only on an accepted push. Entries are not cleared by flush or reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_instruction, bus.in_npc};
    end
  end

  // Pointer and occupancy tracking. Flush rewinds the pointers and overrides both handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head presentation. An empty queue shows a NOP, so decode sees a harmless bubble.
  always_comb begin
    head                = mem[rd_ptr];
    bus.in_ready        = in_ready;
    bus.out_valid       = out_valid;
    bus.count           = count_q;
    bus.out_instruction = out_valid ? head[2*DATA_W-1:DATA_W] : NOP_WORD;
    bus.out_npc         = out_valid ? head[DATA_W-1:0]        : '0;
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue. A queue-based reference model tracks
// the expected contents, and a compare process checks every output on
// every falling edge. Literal checks pin the key moments of each scenario.
module tb_if_id_queue;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  if_id_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  if_id_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each entry is {instruction, npc}; the front is the head.
  logic [31:0] model_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (bus.flush) begin
      model_q.delete();
    end else begin
      automatic bit rdy = (model_q.size() < DEPTH) || bus.out_ready;
      automatic bit do_pop  = (model_q.size() != 0) && bus.out_ready;
      automatic bit do_push = bus.in_valid && rdy;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({bus.in_instruction, bus.in_npc});
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    automatic int  sz = model_q.size();
    automatic logic [31:0] hd = (sz != 0) ? model_q[0] : 32'h0;
    check("count",     32'(bus.count), 32'(sz));
    check("out_valid", 32'(bus.out_valid), 32'(sz != 0));
    check("out_instr", 32'(bus.out_instruction), {16'h0, hd[31:16]});
    check("out_npc",   32'(bus.out_npc), {16'h0, hd[15:0]});
    check("in_ready",  32'(bus.in_ready), 32'((sz < DEPTH) || bus.out_ready));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push_one(input logic [15:0] ins, input logic [15:0] npc);
    bus.in_valid       = 1'b1;
    bus.in_instruction = ins;
    bus.in_npc         = npc;
    cyc();
    bus.in_valid       = 1'b0;
  endtask

  logic [15:0] exp_w[4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset              = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_instruction = '0;
    bus.in_npc         = '0;
    bus.flush          = 1'b0;
    bus.out_ready      = 1'b0;

    // Asynchronous reset before any clock edge.
    #3 reset = 1'b1;
    #1;
    check("rst_count",    32'(bus.count), 32'd0);
    check("rst_valid",    32'(bus.out_valid), 32'd0);
    check("rst_instr",    32'(bus.out_instruction), 32'h0000);
    check("rst_npc",      32'(bus.out_npc), 32'h0000);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    reset = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Fill the queue with decode stalled, then drain it.
    for (int i = 0; i < 4; i++) begin
      push_one(16'(16'h1111 * (i + 1)), 16'(2 * (i + 1)));
    end
    neg();
    check("fill_count",    32'(bus.count), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    check("fill_model_sz", 32'(model_q.size()), 32'd4);
    cyc();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      neg();
      check("drain_instr", 32'(bus.out_instruction), 32'(16'h1111 * (i + 1)));
      check("drain_npc",   32'(bus.out_npc), 32'(2 * (i + 1)));
      cyc();
    end
    neg();
    check("drain_count", 32'(bus.count), 32'd0);
    check("drain_nop",   32'(bus.out_instruction), 32'h0000);

    // Full queue with a simultaneous push and pop, across pointer wrap.
    cyc();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_one(16'(16'h1111 * (i + 1)), 16'(2 * (i + 1)));
    end
    bus.in_valid       = 1'b1;
    bus.in_instruction = 16'h5555;
    bus.in_npc         = 16'd10;
    bus.out_ready      = 1'b1;
    neg();
    check("full_in_ready", 32'(bus.in_ready), 32'd1);
    check("full_head",     32'(bus.out_instruction), 32'h1111);
    cyc();
    bus.in_valid = 1'b0;
    neg();
    check("pp_count", 32'(bus.count), 32'd4);
    exp_w = '{16'h2222, 16'h3333, 16'h4444, 16'h5555};
    for (int i = 0; i < 4; i++) begin
      check("wrap_instr", 32'(bus.out_instruction), 32'(exp_w[i]));
      cyc();
      neg();
    end
    check("wrap_count", 32'(bus.count), 32'd0);

    // Stall with two entries queued.
    cyc();
    bus.out_ready = 1'b0;
    push_one(16'h6666, 16'h0020);
    push_one(16'h7777, 16'h0022);
    for (int i = 0; i < 5; i++) begin
      neg();
      check("stall_instr", 32'(bus.out_instruction), 32'h6666);
      check("stall_count", 32'(bus.count), 32'd2);
      cyc();
    end
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    bus.out_ready = 1'b0;

    // Flush together with a push.
    push_one(16'h8888, 16'h0030);
    push_one(16'h9999, 16'h0032);
    push_one(16'hA0A0, 16'h0034);
    bus.in_valid       = 1'b1;
    bus.in_instruction = 16'hAAAA;
    bus.in_npc         = 16'h0036;
    bus.flush          = 1'b1;
    cyc();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    neg();
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_instr", 32'(bus.out_instruction), 32'h0000);
    cyc();
    push_one(16'hBBBB, 16'h0040);
    neg();
    check("post_flush_instr", 32'(bus.out_instruction), 32'hBBBB);
    check("post_flush_count", 32'(bus.count), 32'd1);
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;

    // Reset during traffic.
    push_one(16'hC1C1, 16'h0050);
    push_one(16'hC2C2, 16'h0052);
    push_one(16'hC3C3, 16'h0054);
    bus.in_valid       = 1'b1;
    bus.in_instruction = 16'hC4C4;
    bus.in_npc         = 16'h0056;
    #1;
    check("pre_rst_count", 32'(bus.count), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    reset              = 1'b0;
    bus.in_instruction = 16'h0123;
    bus.in_npc         = 16'h0456;
    cyc();
    bus.in_valid = 1'b0;
    neg();
    check("after_rst_instr", 32'(bus.out_instruction), 32'h0123);
    check("after_rst_npc",   32'(bus.out_npc), 32'h0456);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
